uart_cmd_rx: RTL and testbench

//  UART receive path and ASCII command parser; the host-to-FPGA counterpart of the friction-factor UART transmitter.

---
 rtl/uart_pkg.sv | 58 +++++
 rtl/uart_byte_rx.sv | 90 +++++++++
 rtl/uart_cmd_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII codes, parser/receiver state enums,
// Q9.10 field widths and small decode helpers.
package uart_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_G     = 8'h47;
  localparam logic [7:0] CH_SP    = 8'h20;

  localparam int INT_W  = 9;
  localparam int FRAC_W = 10;
  localparam int CMD_W  = 1 + INT_W + FRAC_W;

  typedef enum logic [3:0] {
    PS_IDLE,
    PS_CHN,
    PS_SIGN,
    PS_INT0,
    PS_INT1,
    PS_INT2,
    PS_DOT,
    PS_FRAC0,
    PS_FRAC1,
    PS_FRAC2,
    PS_TERM,
    PS_ERR
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR);
  endfunction

  // acc*10 + d, kept at 10 bits (three digits never exceed 999)
  function automatic logic [9:0] mac10(
    input logic [9:0] acc,
    input logic [3:0] d
  );
    return (acc << 3) + (acc << 1) + {6'd0, d};
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, start-edge detect, mid-bit sampling.
// Ports: clk, rst (async high), rx_i serial in -> byte_o, byte_vld, frame_err.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV + 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic w_rx;
  logic w_fall;
  logic w_half;
  logic w_full;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_half = (r_cnt == CW'(HALF - 1));
  assign w_full = (r_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx_i};
      r_prev <= w_rx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Counter restarts on every state change and at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      if (r_state == RX_IDLE || w_next != r_state || w_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_IDLE)
        r_bit <= 3'd0;
      else if (r_state == RX_DATA && w_full) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    byte_o    = r_shift;
    byte_vld  = (r_state == RX_STOP) && w_full && w_rx;
    frame_err = ((r_state == RX_START) && w_half && w_rx) ||
                ((r_state == RX_STOP) && w_full && !w_rx);
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: value commands "<c><+|-><ddd>.<ddd><term>" and
// stop/go "X<c><term>" / "G<c><term>". Ports: clk, rst, uart_rx in;
// cmd_valid, cmd_chn, cmd_data (sign-mag Q9.10), stop_o, rx_err, cmd_err out.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int NUM_CHN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic             cmd_valid,
  output logic [2:0]       cmd_chn,
  output logic [CMD_W-1:0] cmd_data,
  output logic [3:0]       stop_o,
  output logic             rx_err,
  output logic             cmd_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;

  logic [7:0] w_byte;
  logic       w_bvld;
  logic       w_ferr;

  uart_byte_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (uart_rx),
    .byte_o   (w_byte),
    .byte_vld (w_bvld),
    .frame_err(w_ferr)
  );

  assign rx_err = w_ferr;

  parse_state_t r_ps;
  parse_state_t w_ps_next;

  logic [2:0]  r_chn;
  logic        r_sg;
  logic        r_stop;
  logic        r_sign;
  logic [9:0]  r_int;
  logic [9:0]  r_frac;
  logic [9:0]  r_frac10;
  logic        r_pend;

  logic       w_digit;
  logic       w_term;
  logic       w_chn_ok;
  logic       w_xg;
  logic       w_ok;
  logic [3:0] w_dval;

  logic w_done;
  logic w_val_done;
  logic w_sg_done;
  logic w_err_pulse;

  assign w_digit  = is_digit(w_byte);
  assign w_term   = is_term(w_byte);
  assign w_chn_ok = (w_byte >= CH_0) && (w_byte < 8'(CH_0 + NUM_CHN));
  assign w_xg     = (w_byte == CH_X) || (w_byte == CH_G);
  assign w_dval   = w_byte[3:0];

  // Is the current byte acceptable in the current parser state?
  always_comb begin
    w_ok = 1'b0;
    unique case (r_ps)
      PS_IDLE:  w_ok = w_chn_ok || w_xg || w_term ||
                       (w_byte == CH_SP);
      PS_CHN:   w_ok = w_chn_ok;
      PS_SIGN:  w_ok = (w_byte == CH_PLUS) ||
                       (w_byte == CH_MINUS);
      PS_INT0,
      PS_INT1,
      PS_INT2,
      PS_FRAC0,
      PS_FRAC1,
      PS_FRAC2: w_ok = w_digit;
      PS_DOT:   w_ok = (w_byte == CH_DOT);
      PS_TERM:  w_ok = w_term;
      PS_ERR:   w_ok = 1'b1;
      default:  w_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ps <= PS_IDLE;
    else     r_ps <= w_ps_next;
  end

  // A bad byte that is itself a terminator already closes the
  // command, so it returns straight to IDLE instead of waiting in ERR.
  always_comb begin
    w_ps_next = r_ps;
    if (w_bvld) begin
      if (!w_ok)
        w_ps_next = w_term ? PS_IDLE : PS_ERR;
      else begin
        unique case (r_ps)
          PS_IDLE: begin
            if (w_xg)          w_ps_next = PS_CHN;
            else if (w_chn_ok) w_ps_next = PS_SIGN;
          end
          PS_CHN:   w_ps_next = PS_TERM;
          PS_SIGN:  w_ps_next = PS_INT0;
          PS_INT0:  w_ps_next = PS_INT1;
          PS_INT1:  w_ps_next = PS_INT2;
          PS_INT2:  w_ps_next = PS_DOT;
          PS_DOT:   w_ps_next = PS_FRAC0;
          PS_FRAC0: w_ps_next = PS_FRAC1;
          PS_FRAC1: w_ps_next = PS_FRAC2;
          PS_FRAC2: w_ps_next = PS_TERM;
          PS_TERM:  w_ps_next = PS_IDLE;
          PS_ERR:   if (w_term) w_ps_next = PS_IDLE;
          default:  w_ps_next = PS_IDLE;
        endcase
      end
    end
  end

  // Integer overflow (any value >= 512 sets bit 9) is caught on the
  // terminator; the command is already closed, so no ERR wait.
  always_comb begin
    w_done      = w_bvld && (r_ps == PS_TERM) && w_term;
    w_val_done  = w_done && !r_sg && !r_int[9];
    w_sg_done   = w_done && r_sg;
    w_err_pulse = (w_bvld && !w_ok) ||
                  (w_done && !r_sg && r_int[9]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chn  <= 3'd0;
      r_sg   <= 1'b0;
      r_stop <= 1'b0;
      r_sign <= 1'b0;
      r_int  <= 10'd0;
      r_frac <= 10'd0;
    end else if (w_bvld && w_ok) begin
      case (r_ps)
        PS_IDLE: begin
          r_sg   <= w_xg;
          r_stop <= (w_byte == CH_X);
          r_chn  <= w_byte[2:0];
          r_sign <= 1'b0;
          r_int  <= 10'd0;
          r_frac <= 10'd0;
        end
        PS_CHN:  r_chn  <= w_byte[2:0];
        PS_SIGN: r_sign <= (w_byte == CH_MINUS);
        PS_INT0,
        PS_INT1,
        PS_INT2: r_int  <= mac10(r_int, w_dval);
        PS_FRAC0,
        PS_FRAC1,
        PS_FRAC2: r_frac <= mac10(r_frac, w_dval);
        default: ;
      endcase
    end
  end

  // Stage 1: thousandths -> 1/1024 units. Stage 2: output register.
  // Parser fields stay stable across both stages since the next
  // byte is at least a full character time away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_frac10  <= 10'd0;
      cmd_valid <= 1'b0;
      cmd_chn   <= 3'd0;
      cmd_data  <= '0;
      cmd_err   <= 1'b0;
      stop_o    <= 4'd0;
    end else begin
      r_pend    <= w_val_done;
      r_frac10  <= 10'(({r_frac, 10'd0}) / 20'd1000);
      cmd_valid <= r_pend;
      cmd_err   <= w_err_pulse;
      if (r_pend) begin
        cmd_chn  <= r_chn;
        cmd_data <= {r_sign, r_int[8:0], r_frac10};
      end
      if (w_sg_done)
        stop_o[r_chn[1:0]] <= r_stop;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial byte driver plus a
// scoreboard of expected value commands checked on cmd_valid.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        cmd_valid;
  logic [2:0]  cmd_chn;
  logic [19:0] cmd_data;
  logic [3:0]  stop_o;
  logic        rx_err;
  logic        cmd_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_cerr  = 0;
  int n_rerr  = 0;

  logic [22:0] sb_q[$];
  logic [22:0] sb_e;

  uart_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD),
    .NUM_CHN  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .cmd_valid(cmd_valid),
    .cmd_chn  (cmd_chn),
    .cmd_data (cmd_data),
    .stop_o   (stop_o),
    .rx_err   (rx_err),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        n_valid++;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("cmd_chn", 32'(cmd_chn), 32'(sb_e[22:20]));
          check("cmd_data", 32'(cmd_data), 32'(sb_e[19:0]));
        end
      end
      if (cmd_err) n_cerr++;
      if (rx_err)  n_rerr++;
    end
  end

  task automatic send_byte(
    input logic [7:0] b,
    input logic       stop_bit = 1'b1
  );
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  task automatic settle();
    for (int i = 0; i < 4 * DIV && sb_q.size() != 0; i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outs",
          32'({cmd_valid, cmd_chn, cmd_data, stop_o, rx_err, cmd_err}),
          32'd0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    sb_q.push_back({3'd2, 20'h1EE00});
    send_str("2+123.500\n");
    settle();
    check("cerr_after_cmd1", 32'(n_cerr), 32'd0);

    sb_q.push_back({3'd1, 20'h81500});
    send_str("1-005.250\r\n");
    settle();
    check("cerr_crlf", 32'(n_cerr), 32'd0);
    check("valid_cnt2", 32'(n_valid), 32'd2);

    send_str("X3\n");
    repeat (4) @(negedge clk);
    check("stop_x3", 32'(stop_o), 32'h8);
    send_str("G3\n");
    repeat (4) @(negedge clk);
    check("stop_g3", 32'(stop_o), 32'h0);
    check("valid_sg", 32'(n_valid), 32'd2);

    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("rxerr_glitch", 32'(n_rerr), 32'd1);

    send_byte(8'h41, 1'b0);
    repeat (4) @(negedge clk);
    check("rxerr_stop", 32'(n_rerr), 32'd2);
    check("no_byte_on_ferr", 32'(n_cerr), 32'd0);

    sb_q.push_back({3'd0, 20'h80000});
    send_str("0-000.000\n");
    settle();

    sb_q.push_back({3'd3, 20'h7FFFE});
    send_str("3+511.999\n");
    settle();

    send_str("2+600.000\n");
    repeat (4) @(negedge clk);
    check("cerr_ovf", 32'(n_cerr), 32'd1);
    send_str("5+001.000\n");
    repeat (4) @(negedge clk);
    check("cerr_chn", 32'(n_cerr), 32'd2);
    send_str("2+1x\n");
    repeat (4) @(negedge clk);
    check("cerr_digit", 32'(n_cerr), 32'd3);
    check("valid_errs", 32'(n_valid), 32'd4);
    check("hold_data", 32'(cmd_data), 32'h7FFFE);
    check("hold_chn", 32'(cmd_chn), 32'd3);

    sb_q.push_back({3'd3, 20'h00880});
    send_str("3+002.125\n");
    settle();

    send_str("X1\n");
    repeat (4) @(negedge clk);
    check("stop_x1", 32'(stop_o), 32'h2);

    send_str("3+010.");
    uart_rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check("midrst_outs",
          32'({cmd_valid, cmd_chn, cmd_data, stop_o, rx_err, cmd_err}),
          32'd0);

    sb_q.push_back({3'd0, 20'h007FE});
    send_str("0+001.999\n");
    settle();

    check("valid_total", 32'(n_valid), 32'd6);
    check("rxerr_total", 32'(n_rerr), 32'd2);
    check("cerr_total", 32'(n_cerr), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
